// File: rtl/uart_fifo_mm_if.sv
// CPU port-b bus bundle for the memory-mapped UART buffer.
// The master drives address, write data and write enable.
// The slave returns combinational read data and an address-hit strobe.
interface uart_fifo_mm_if;
    logic [31:0] addr_b;
    logic [31:0] data_b_in;
    logic [31:0] data_b_we;
    logic [31:0] data_b;
    logic        strobe_b;

    modport master (
        output addr_b,
        output data_b_in,
        output data_b_we,
        input  data_b,
        input  strobe_b
    );

    modport slave (
        input  addr_b,
        input  data_b_in,
        input  data_b_we,
        output data_b,
        output strobe_b
    );
endinterface

// File: rtl/uart_fifo_mm.sv
// Memory-mapped UART buffer: RX FIFO fed by the PHY, TX FIFO drained into the
// PHY, a sticky RX overflow flag and a registered level IRQ.
// Register map: BASE = RX status, BASE+1 = TX status, BASE+2 = data.
module uart_fifo_mm #(
    parameter logic [31:0] BASE       = 32'd65537,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_din,
    input  logic       uart_valid,
    input  logic       uart_busy,
    output logic [7:0] uart_dout,
    output logic       uart_wr,
    output logic       rx_irq,
    uart_fifo_mm_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ZERO = CW'(0);

    logic [7:0]            rx_mem [DEPTH];
    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_head_r, rx_tail_r, tx_head_r, tx_tail_r;
    logic [CW-1:0]         rx_count_r, tx_count_r;
    logic                  ovf_r;

    logic       sel_stat_s, sel_data_s, wr_access_s;
    logic       rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic       rx_pop_s, rx_push_s, ovf_set_s, ovf_nxt_s;
    logic       tx_pop_s, tx_push_s;
    logic [7:0] rx_count8_s, tx_count8_s;

    assign sel_stat_s  = (bus.addr_b == BASE);
    assign sel_data_s  = (bus.addr_b == (BASE + 32'd2));
    assign wr_access_s = (bus.data_b_we != 32'd0);

    assign rx_empty_s = (rx_count_r == CNT_ZERO);
    assign rx_full_s  = (rx_count_r == CNT_FULL);
    assign tx_empty_s = (tx_count_r == CNT_ZERO);
    assign tx_full_s  = (tx_count_r == CNT_FULL);

    assign rx_count8_s = {{(8 - CW){1'b0}}, rx_count_r};
    assign tx_count8_s = {{(8 - CW){1'b0}}, tx_count_r};

    // FIFO handshake decisions; a same-cycle pop makes room for a push into a full FIFO.
    always_comb begin
        rx_pop_s  = sel_data_s & ~wr_access_s & ~rx_empty_s;
        rx_push_s = uart_valid & (~rx_full_s | rx_pop_s);
        ovf_set_s = uart_valid & rx_full_s & ~rx_pop_s;
        if (ovf_set_s) begin
            ovf_nxt_s = 1'b1;
        end else if (sel_stat_s && !wr_access_s) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
        tx_pop_s  = ~tx_empty_s & ~uart_busy & ~uart_wr;
        tx_push_s = sel_data_s & wr_access_s & (~tx_full_s | tx_pop_s);
    end

    // Combinational read mux for the three mapped words.
    always_comb begin
        bus.data_b   = 32'd0;
        bus.strobe_b = 1'b0;
        case (bus.addr_b)
            BASE: begin
                bus.strobe_b = 1'b1;
                bus.data_b   = {15'd0, ovf_r, rx_count8_s, 7'd0, ~rx_empty_s};
            end
            BASE + 32'd1: begin
                bus.strobe_b = 1'b1;
                bus.data_b   = {16'd0, tx_count8_s, 7'd0, ~tx_full_s};
            end
            BASE + 32'd2: begin
                bus.strobe_b = 1'b1;
                if (rx_empty_s) begin
                    bus.data_b = 32'd0;
                end else begin
                    bus.data_b = {24'd0, rx_mem[rx_head_r]};
                end
            end
            default: begin
                bus.strobe_b = 1'b0;
                bus.data_b   = 32'd0;
            end
        endcase
    end

    // FIFO storage; contents need no reset because counts gate every read.
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem[rx_tail_r] <= uart_din;
        end
        if (tx_push_s) begin
            tx_mem[tx_tail_r] <= bus.data_b_in[7:0];
        end
    end

    // Pointers, counts, overflow flag, transmit strobe and IRQ register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_head_r  <= '0;
            rx_tail_r  <= '0;
            rx_count_r <= '0;
            tx_head_r  <= '0;
            tx_tail_r  <= '0;
            tx_count_r <= '0;
            ovf_r      <= 1'b0;
            uart_wr    <= 1'b0;
            uart_dout  <= 8'd0;
            rx_irq     <= 1'b0;
        end else begin
            if (rx_push_s) begin
                rx_tail_r <= rx_tail_r + PTR_ONE;
            end
            if (rx_pop_s) begin
                rx_head_r <= rx_head_r + PTR_ONE;
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + CNT_ONE;
                2'b01:   rx_count_r <= rx_count_r - CNT_ONE;
                default: rx_count_r <= rx_count_r;
            endcase

            if (tx_push_s) begin
                tx_tail_r <= tx_tail_r + PTR_ONE;
            end
            if (tx_pop_s) begin
                tx_head_r <= tx_head_r + PTR_ONE;
                uart_dout <= tx_mem[tx_head_r];
            end
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + CNT_ONE;
                2'b01:   tx_count_r <= tx_count_r - CNT_ONE;
                default: tx_count_r <= tx_count_r;
            endcase

            uart_wr <= tx_pop_s;
            ovf_r   <= ovf_nxt_s;
            rx_irq  <= ~rx_empty_s | ovf_r;
        end
    end
endmodule

// File: tb/tb_uart_fifo_mm.sv
// Self-checking bench for uart_fifo_mm: directed test-plan steps followed by
// randomized traffic, compared against a queue-based reference model.
module tb_uart_fifo_mm;
    localparam logic [31:0] BASE = 32'd65537;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] uart_din;
    logic       uart_valid;
    logic       uart_busy;
    logic [7:0] uart_dout;
    logic       uart_wr;
    logic       rx_irq;

    uart_fifo_mm_if bus ();

    uart_fifo_mm #(.BASE(BASE), .DEPTH_LOG2(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_din   (uart_din),
        .uart_valid (uart_valid),
        .uart_busy  (uart_busy),
        .uart_dout  (uart_dout),
        .uart_wr    (uart_wr),
        .rx_irq     (rx_irq),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit         ovf_m, wr_m, irq_m;
    logic [7:0] dout_m;

    logic [31:0] last_rd;
    logic [7:0]  tx_log[$];
    int          tx_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (a == BASE)
            r = {15'd0, ovf_m, 8'(rxq.size()), 7'd0, rxq.size() != 0};
        else if (a == BASE + 32'd1)
            r = {16'd0, 8'(txq.size()), 7'd0, txq.size() < 16};
        else if (a == BASE + 32'd2)
            r = (rxq.size() != 0) ? {24'd0, rxq[0]} : 32'd0;
        return r;
    endfunction

    // One clock cycle: drive, check reads, advance model at the edge, check registers.
    task automatic step(input bit vld, input logic [7:0] din, input bit busy,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] we);
        bit pop, ovf_set, drain, push, is_we, irq_nxt;
        @(negedge clk);
        uart_valid    = vld;
        uart_din      = din;
        uart_busy     = busy;
        bus.addr_b    = addr;
        bus.data_b_in = wdata;
        bus.data_b_we = we;
        #1;
        last_rd = bus.data_b;
        check("read_data", bus.data_b, model_rd(addr));
        check("strobe", {31'd0, bus.strobe_b},
              {31'd0, (addr == BASE) || (addr == BASE + 32'd1) || (addr == BASE + 32'd2)});
        @(posedge clk);
        cyc++;
        if (!rst) begin
            rxq.delete(); txq.delete();
            ovf_m = 1'b0; wr_m = 1'b0; irq_m = 1'b0; dout_m = 8'd0;
        end else begin
            is_we   = (we != 32'd0);
            irq_nxt = (rxq.size() != 0) || ovf_m;
            pop     = (addr == BASE + 32'd2) && !is_we && (rxq.size() != 0);
            ovf_set = vld && (rxq.size() == 16) && !pop;
            if (pop) void'(rxq.pop_front());
            if (vld && !ovf_set) rxq.push_back(din);
            ovf_m = ovf_set || (ovf_m && !((addr == BASE) && !is_we));
            drain = (txq.size() != 0) && !busy && !wr_m;
            push  = (addr == BASE + 32'd2) && is_we && ((txq.size() < 16) || drain);
            if (drain) dout_m = txq.pop_front();
            wr_m = drain;
            if (push) txq.push_back(wdata[7:0]);
            irq_m = irq_nxt;
        end
        #1;
        check("uart_wr", {31'd0, uart_wr}, {31'd0, wr_m});
        check("uart_dout", {24'd0, uart_dout}, {24'd0, dout_m});
        check("rx_irq", {31'd0, rx_irq}, {31'd0, irq_m});
        if (uart_wr) begin
            tx_log.push_back(uart_dout);
            tx_cyc.push_back(cyc);
        end
    endtask

    task automatic idle(input bit busy);
        step(1'b0, 8'd0, busy, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        int r;
        logic [31:0] a, w;
        rst = 1'b0;
        ovf_m = 1'b0; wr_m = 1'b0; irq_m = 1'b0; dout_m = 8'd0;

        // power-up reset
        idle(1'b0);
        idle(1'b0);
        rst = 1'b1;

        // reset with FIFOs partially full
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b1, BASE + 32'd2, 32'h55, 32'd1);
        rst = 1'b0;
        idle(1'b1);
        idle(1'b1);
        rst = 1'b1;
        step(1'b0, 8'd0, 1'b1, BASE, 32'd0, 32'd0);
        check("rst_base", last_rd, 32'h0000_0000);
        check("rst_irq", {31'd0, rx_irq}, 32'd0);
        check("rst_wr", {31'd0, uart_wr}, 32'd0);
        step(1'b0, 8'd0, 1'b0, BASE + 32'd1, 32'd0, 32'd0);
        check("rst_txstat", last_rd, 32'h0000_0001);

        // RX ordering
        step(1'b1, 8'h41, 1'b0, 32'd0, 32'd0, 32'd0);
        step(1'b1, 8'h42, 1'b0, 32'd0, 32'd0, 32'd0);
        step(1'b1, 8'h43, 1'b0, 32'd0, 32'd0, 32'd0);
        step(1'b0, 8'd0, 1'b0, BASE, 32'd0, 32'd0);
        check("rx_stat3", last_rd, 32'h0000_0301);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'd0, 1'b0, BASE + 32'd2, 32'd0, 32'd0);
            check("rx_order", last_rd, 32'h41 + 32'(i));
        end
        check("irq_held_at_last_pop", {31'd0, rx_irq}, 32'd1);
        step(1'b0, 8'd0, 1'b0, BASE + 32'd2, 32'd0, 32'd0);
        check("rx_empty_read", last_rd, 32'd0);
        check("irq_fell", {31'd0, rx_irq}, 32'd0);

        // RX overflow
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 32'd0, 32'd0, 32'd0);
        step(1'b0, 8'd0, 1'b0, BASE, 32'd0, 32'd0);
        check("ovf_stat", last_rd, 32'h0001_1001);
        step(1'b0, 8'd0, 1'b0, BASE, 32'd0, 32'd0);
        check("ovf_cleared", last_rd, 32'h0000_1001);

        // RX full boundary: push and pop in the same cycle
        step(1'b1, 8'h99, 1'b0, BASE + 32'd2, 32'd0, 32'd0);
        check("full_pop_data", last_rd, 32'h0000_0000);
        step(1'b0, 8'd0, 1'b0, BASE, 32'd0, 32'd0);
        check("full_boundary_stat", last_rd, 32'h0000_1001);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 8'd0, 1'b0, BASE + 32'd2, 32'd0, 32'd0);
            check("ovf_data", last_rd, 32'(i));
        end
        step(1'b0, 8'd0, 1'b0, BASE + 32'd2, 32'd0, 32'd0);
        check("full_new_last", last_rd, 32'h0000_0099);

        // TX drain
        tx_log.delete(); tx_cyc.delete();
        step(1'b0, 8'd0, 1'b0, BASE + 32'd2, 32'hAA, 32'd1);
        step(1'b0, 8'd0, 1'b0, BASE + 32'd2, 32'hBB, 32'hF0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        check("tx_cnt", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() == 2) begin
            check("tx_b0", {24'd0, tx_log[0]}, 32'hAA);
            check("tx_b1", {24'd0, tx_log[1]}, 32'hBB);
            check("tx_gap", 32'(tx_cyc[1] - tx_cyc[0]), 32'd2);
        end

        // busy stall and resume
        tx_log.delete();
        step(1'b0, 8'd0, 1'b1, BASE + 32'd2, 32'h11, 32'd1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("tx_stalled", 32'(tx_log.size()), 32'd0);
        idle(1'b0);
        check("tx_resumed", 32'(tx_log.size()), 32'd1);
        idle(1'b0);

        // TX full
        tx_log.delete();
        for (int i = 0; i < 17; i++) step(1'b0, 8'd0, 1'b1, BASE + 32'd2, 32'h20 + 32'(i), 32'd1);
        step(1'b0, 8'd0, 1'b1, BASE + 32'd1, 32'd0, 32'd0);
        check("tx_full_stat", last_rd, 32'h0000_1000);
        for (int i = 0; i < 40; i++) idle(1'b0);
        check("tx_full_cnt", 32'(tx_log.size()), 32'd16);
        for (int i = 0; i < tx_log.size(); i++) check("tx_full_order", {24'd0, tx_log[i]}, 32'h20 + 32'(i));

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: a = BASE;
                1: a = BASE + 32'd1;
                2, 3: a = BASE + 32'd2;
                4: a = BASE + 32'd3;
                default: a = 32'd0;
            endcase
            w = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
            rst = ($urandom_range(0, 199) != 0);
            step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) == 0, a, $urandom, w);
        end
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_fifo_mm.md
Name: uart_fifo_mm

Overview:
Memory-mapped UART buffer that sits between the UART PHY (rx/tx byte streams) and the CPU data port b. It replaces single-byte holding registers with an RX FIFO, a TX FIFO, a sticky overflow flag and a level IRQ. The CPU can therefore absorb bursts without polling every byte.

Parameters:
BASE, 65537, address of RX status word; TX status at BASE+1, data at BASE+2
DEPTH_LOG2, 4, log2 of each FIFO depth (DEPTH = 16 entries)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
uart_din  in  8  received byte from PHY
uart_valid  in  1  one-cycle strobe, uart_din valid
uart_busy  in  1  PHY transmitter busy
uart_dout  out  8  byte to transmit
uart_wr  out  1  one-cycle transmit strobe
rx_irq  out  1  level IRQ: RX FIFO non-empty or overflow set
data_b  out  32  read data (combinational from addr_b)
strobe_b  out  1  high when addr_b is in BASE..BASE+2
addr_b  in  32  CPU port-b address
data_b_in  in  32  CPU write data
data_b_we  in  32  write enable; any nonzero value means write

Behaviour:
- Reset (rst==0 at posedge): RX/TX pointers and counts = 0, overflow = 0, uart_wr = 0, uart_dout = 0. FIFO contents are undefined.
- Reset mid-operation discards all queued bytes. No uart_wr is issued in the cycle after reset deasserts.
- Read map (combinational):
  - BASE: {15'b0, ovf, rx_count[7:0], 7'b0, rx_nonempty}
  - BASE+1: {tx_count[7:0] in bits 15:8, bit0 = tx_not_full}
  - BASE+2: {24'b0, rx_head}, or 0 when RX is empty
  - Any other address: data_b = 0, strobe_b = 0.
- Access timing: each cycle with a matching address counts as one access. The master presents an address for exactly one cycle per access.
- RX push: on uart_valid, uart_din is written at the tail when RX is not full. If RX is full, the byte is dropped and ovf is set.
  - A same-cycle pop frees the slot, so the push succeeds and the count is unchanged.
- RX pop: addr_b==BASE+2 with we==0 and RX non-empty advances the head at the clock edge. Reading while empty has no effect.
- RX visibility: a byte strobed at cycle N is visible in status/data at N+1.
- ovf: sticky. Cleared by a read of BASE (we==0) unless a new overflow occurs in the same cycle; set wins.
- TX push: addr_b==BASE+2 with we!=0 writes data_b_in[7:0] to the TX tail if not full. A write while full is silently dropped.
- TX drain:
  - Condition: TX non-empty, uart_busy==0 and uart_wr==0 in cycle N.
  - Action at the N edge: uart_dout <= head, pop, uart_wr <= 1.
  - uart_wr is high for exactly one cycle (N+1) and then returns to 0.
  - Maximum rate is one byte per 2 cycles.
- TX simultaneous push and drain when full: the push succeeds.
- Counts are DEPTH_LOG2+1 bits wide and zero-extended into the 8-bit fields. Pointers wrap modulo DEPTH.
- rx_irq = rx_nonempty | ovf, registered (asserts one cycle after the causing edge).
- Writes to BASE or BASE+1 are ignored.

Test Plan:
- Reset: hold rst=0 for 2 cycles with FIFOs partially full -> all counts 0, uart_wr=0, rx_irq=0, read BASE returns 0, read BASE+1 returns 0x00000001.
- RX ordering: strobe 0x41, 0x42, 0x43 -> BASE reads 0x00000301. Three reads of BASE+2 return 0x41, 0x42, 0x43. A fourth read returns 0 with no pop. rx_irq falls one cycle after the last pop.
- RX overflow: push 17 bytes 0x00..0x10 -> count 16 and ovf=1 (BASE reads 0x00011001). Data reads return 0x00..0x0F (0x10 was dropped). Reading BASE clears ovf.
- RX full boundary: RX full, uart_valid and a BASE+2 read in the same cycle -> count stays 16, ovf stays 0, the new byte is read last.
- TX drain: write 0xAA, 0xBB with uart_busy=0 -> uart_wr pulses two cycles apart carrying 0xAA then 0xBB. Holding uart_busy=1 stalls the drain. Deasserting it resumes within 1 cycle.
- TX full: 17 writes while uart_busy=1 -> BASE+1 reads 0x00001000 (not_full=0). Releasing busy transmits exactly 16 bytes in order.
